dmem_loader: RTL and testbench
==============================

Name: dmem_loader

Overview:
- Host-side loader and unloader for the core's data memory.
- While the core is held in reset, it streams bytes from a host into DMem. It then releases the core and waits for `done`.
- It then freezes the core again and streams a DMem window back out to the host.
- It owns the DMem port whenever `core_hold` is high; the top-level muxes DMem `Wen`/`Addr`/`WDat` to this block on `core_hold`.

Parameters:
- ADDR_W, 8, DMem address width; all address arithmetic is modulo 2^ADDR_W.
- CNT_W, 9, byte-count width; allows counts 0..256.
- TIMEOUT, 4096, RUN-phase watchdog limit in cycles (used only with LOADER_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; begins a LOAD/RUN/DUMP sequence
- ld_base  in  ADDR_W  first DMem address written; latched on accepted start
- ld_cnt  in  CNT_W  bytes to load; latched on accepted start
- dp_base  in  ADDR_W  first DMem address read back; latched on accepted start
- dp_cnt  in  CNT_W  bytes to dump; latched on accepted start
- in_valid  in  1  host write byte valid
- in_data  in  8  host write byte
- in_ready  out  1  loader accepts in_data
- out_valid  out  1  dump byte valid (registered)
- out_data  out  8  dump byte (registered)
- out_ready  in  1  host accepts out_data
- mem_wen  out  1  DMem write enable
- mem_addr  out  ADDR_W  DMem address
- mem_wdat  out  8  DMem write data
- mem_rdat  in  8  DMem read data (combinational read of mem_addr)
- core_done  in  1  core `done` level
- core_hold  out  1  holds core in reset and gives the DMem port to the loader
- busy  out  1  high in LOAD, RUN, DUMP
- finished  out  1  high in FIN
- timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (synchronous, active-high) values:
  - state=IDLE, idx=0, out_valid=0, out_data=0, timeout=0.
  - Latched config is all zeros.
  - core_hold=1, busy=0, finished=0.
  - in_ready=0, mem_wen=0, mem_addr=0, mem_wdat=0.
- Reset mid-operation aborts the sequence on the next edge. There is no partial dump and no flag is retained.
- State IDLE:
  - core_hold=1.
  - start latches the config, clears idx and timeout, and goes to LOAD.
  - If ld_cnt==0, go directly to RUN.
- State LOAD:
  - in_ready=1.
  - mem_wen = in_valid (combinational); mem_addr = ld_base+idx (wrap); mem_wdat = in_data.
  - Each in_valid&in_ready writes in the same cycle and increments idx.
  - On the write with idx==ld_cnt-1: clear idx and go to RUN.
- State RUN:
  - core_hold=0, in_ready=0, mem_wen=0, mem_addr=0.
  - The core owns DMem.
  - core_done sampled high goes to DUMP; idx=0, core_hold rises next cycle.
  - If dp_cnt==0, go directly to FIN.
- State DUMP:
  - core_hold=1, mem_addr = dp_base+idx (wrap), mem_wen=0.
  - Fetch condition: (!out_valid | out_ready) & idx<dp_cnt. On fetch: out_data<=mem_rdat, out_valid<=1, idx++.
  - If out_valid&out_ready and no fetch: out_valid<=0.
  - out_data must stay stable while out_valid&!out_ready.
  - First out_valid appears one cycle after entering DUMP. With out_ready held high, throughput is 1 byte/cycle.
  - When the last byte is accepted (idx==dp_cnt and out_valid&out_ready): go to FIN.
- State FIN:
  - core_hold=1, finished=1.
  - start is accepted exactly as in IDLE (finished drops, goes to LOAD).
- start is ignored in LOAD, RUN and DUMP.
- Address wrap: base 0xFE with count 4 touches 0xFE, 0xFF, 0x00, 0x01.
- Count 256 covers all of DMem.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Enabled:
  - A cycle counter is cleared on RUN entry and counts while in RUN.
  - When it reaches TIMEOUT-1 without core_done: set timeout (sticky until next accepted start or reset) and go to DUMP normally.
  - core_done and expiry in the same cycle: core_done wins, timeout stays 0.
- Disabled:
  - No counter; RUN waits indefinitely.
  - timeout is tied to 0.

Test Plan:
- Basic round-trip:
  - Stimulus: reset; start with ld_base=0x10, ld_cnt=3, dp_base=0x10, dp_cnt=3; feed 0xA1, 0xB2, 0xC3 back-to-back.
  - Required: mem_wen at 0x10..0x12 in 3 consecutive cycles; core_hold falls.
  - Then: stub core asserts core_done after 5 cycles; out stream is 0xA1, 0xB2, 0xC3; finished=1.
- Backpressure:
  - Stimulus: dump 4 bytes with out_ready toggling 1,0,0,1,...
  - Required: out_data holds while stalled; no byte is lost or duplicated; order is preserved.
- Wrap and zero counts:
  - Stimulus 1: ld_base=0xFE, ld_cnt=4.
  - Required 1: writes to 0xFE, 0xFF, 0x00, 0x01.
  - Stimulus 2: ld_cnt=0, dp_cnt=0.
  - Required 2: IDLE→RUN→FIN with no mem_wen and no out_valid.
- Input gaps:
  - Stimulus: in_valid deasserted between bytes.
  - Required: mem_wen only on valid cycles; idx advances only on accepted bytes.
- Reset mid-DUMP:
  - Stimulus: assert reset after 2 of 5 bytes dumped.
  - Required: next cycle state IDLE, out_valid=0, core_hold=1; a new start works normally.
- LOADER_TIMEOUT_EN with TIMEOUT=16, core_done never asserted:
  - Required: timeout=1 after 16 RUN cycles, dump proceeds, finished=1.
  - Same run without the macro: stays in RUN and timeout=0.

Source files
------------

// File: rtl/dmem_loader.sv
// dmem_loader: host-side loader/unloader for the core's data memory.
//
// Sequence per accepted start: LOAD (host bytes into DMem while the core is held),
// RUN (core released until core_done), DUMP (a DMem window streamed back to the host),
// then FIN (parked until the next start).
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   start                 one-cycle request, accepted only in IDLE or FIN
//   ld_base/ld_cnt        load window (latched on accepted start)
//   dp_base/dp_cnt        dump window (latched on accepted start)
//   in_valid/in_data/in_ready     host write byte stream
//   out_valid/out_data/out_ready  registered dump byte stream
//   mem_wen/mem_addr/mem_wdat/mem_rdat  DMem port, owned by this block while core_hold=1
//   core_done             core completion level
//   core_hold             holds the core in reset and selects this block on the DMem mux
//   busy, finished        status: LOAD/RUN/DUMP, FIN
//   timeout               sticky RUN watchdog flag
//
// Optional feature: define LOADER_TIMEOUT_EN to enable the RUN-phase watchdog
// (TIMEOUT cycles). Without it RUN waits for core_done indefinitely and timeout is 0.
module dmem_loader #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned CNT_W   = 9,
   parameter int unsigned TIMEOUT = 4096
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] ld_base,
   input  logic [CNT_W-1:0]  ld_cnt,
   input  logic [ADDR_W-1:0] dp_base,
   input  logic [CNT_W-1:0]  dp_cnt,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [7:0]        out_data,
   input  logic              out_ready,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdat,
   input  logic [7:0]        mem_rdat,
   input  logic              core_done,
   output logic              core_hold,
   output logic              busy,
   output logic              finished,
   output logic              timeout
);

   typedef enum logic [2:0] {StIdle, StLoad, StRun, StDump, StFin} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  idx_q, idx_d;
   logic [ADDR_W-1:0] ld_base_q, ld_base_d, dp_base_q, dp_base_d;
   logic [CNT_W-1:0]  ld_cnt_q, ld_cnt_d, dp_cnt_q, dp_cnt_d;
   logic              out_valid_q, out_valid_d;
   logic [7:0]        out_data_q, out_data_d;
   logic              fetch;

`ifdef LOADER_TIMEOUT_EN
   localparam int unsigned RunCntW = $clog2(TIMEOUT) + 1;
   logic [RunCntW-1:0] run_cnt_q, run_cnt_d;
   logic               timeout_q, timeout_d;
   logic               expired;

   // Counter is zero on every cycle outside RUN, so it starts from 0 on RUN entry.
   assign run_cnt_d = (state_q == StRun) ? run_cnt_q + RunCntW'(1) : '0;
   assign expired   = (run_cnt_q == RunCntW'(TIMEOUT - 1));
   assign timeout   = timeout_q;
`else
   // Watchdog compiled out: the flag is constant low and TIMEOUT has no effect.
   assign timeout = (TIMEOUT == 0) ? 1'b0 : 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      ld_base_d   = ld_base_q;
      ld_cnt_d    = ld_cnt_q;
      dp_base_d   = dp_base_q;
      dp_cnt_d    = dp_cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
`ifdef LOADER_TIMEOUT_EN
      timeout_d   = timeout_q;
`endif
      core_hold   = 1'b1;
      busy        = 1'b0;
      finished    = 1'b0;
      in_ready    = 1'b0;
      mem_wen     = 1'b0;
      mem_addr    = '0;
      mem_wdat    = '0;
      fetch       = 1'b0;

      unique case (state_q)
         StIdle: ;
         StFin: finished = 1'b1;
         StLoad: begin
            busy     = 1'b1;
            in_ready = 1'b1;
            mem_wen  = in_valid;
            mem_addr = ld_base_q + idx_q[ADDR_W-1:0];
            mem_wdat = in_data;
            if (in_valid) begin
               if (idx_q == ld_cnt_q - CNT_W'(1)) begin
                  idx_d   = '0;
                  state_d = StRun;
               end else begin
                  idx_d = idx_q + CNT_W'(1);
               end
            end
         end
         StRun: begin
            busy      = 1'b1;
            core_hold = 1'b0;
            if (core_done) begin
               idx_d   = '0;
               state_d = (dp_cnt_q == '0) ? StFin : StDump;
            end
`ifdef LOADER_TIMEOUT_EN
            else if (expired) begin
               timeout_d = 1'b1;
               idx_d     = '0;
               state_d   = (dp_cnt_q == '0) ? StFin : StDump;
            end
`endif
         end
         StDump: begin
            busy     = 1'b1;
            mem_addr = dp_base_q + idx_q[ADDR_W-1:0];
            // Refill the output register when it is empty or being drained this cycle.
            fetch    = (!out_valid_q || out_ready) && (idx_q < dp_cnt_q);
            if (fetch) begin
               out_data_d  = mem_rdat;
               out_valid_d = 1'b1;
               idx_d       = idx_q + CNT_W'(1);
            end else if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               if (idx_q == dp_cnt_q) state_d = StFin;
            end
         end
         default: state_d = StIdle;
      endcase

      if (start && (state_q == StIdle || state_q == StFin)) begin
         ld_base_d = ld_base;
         ld_cnt_d  = ld_cnt;
         dp_base_d = dp_base;
         dp_cnt_d  = dp_cnt;
         idx_d     = '0;
         state_d   = (ld_cnt == '0) ? StRun : StLoad;
`ifdef LOADER_TIMEOUT_EN
         timeout_d = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         idx_q       <= '0;
         ld_base_q   <= '0;
         ld_cnt_q    <= '0;
         dp_base_q   <= '0;
         dp_cnt_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
`ifdef LOADER_TIMEOUT_EN
         run_cnt_q   <= '0;
         timeout_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         ld_base_q   <= ld_base_d;
         ld_cnt_q    <= ld_cnt_d;
         dp_base_q   <= dp_base_d;
         dp_cnt_q    <= dp_cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
`ifdef LOADER_TIMEOUT_EN
         run_cnt_q   <= run_cnt_d;
         timeout_q   <= timeout_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_dmem_loader.sv
// Self-checking bench for dmem_loader: randomized data against a byte-array model of DMem.
module tb_dmem_loader;
   localparam int unsigned AW = 8;
   localparam int unsigned CW = 9;
   localparam int unsigned TO = 16;

   logic          clk = 1'b0;
   logic          reset, start, in_valid, out_ready, core_done;
   logic [AW-1:0] ld_base, dp_base, mem_addr;
   logic [CW-1:0] ld_cnt, dp_cnt;
   logic [7:0]    in_data, out_data, mem_wdat, mem_rdat;
   logic          in_ready, out_valid, mem_wen, core_hold, busy, finished, timeout;

   dmem_loader #(.ADDR_W(AW), .CNT_W(CW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .start(start),
      .ld_base(ld_base), .ld_cnt(ld_cnt), .dp_base(dp_base), .dp_cnt(dp_cnt),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdat(mem_wdat), .mem_rdat(mem_rdat),
      .core_done(core_done), .core_hold(core_hold), .busy(busy), .finished(finished),
      .timeout(timeout)
   );

   always #5 clk = ~clk;

   // Physical DMem seen by the DUT, and the bench's expected contents.
   logic [7:0] dmem    [256];
   logic [7:0] exp_mem [256];
   assign mem_rdat = dmem[mem_addr];
   always @(posedge clk) if (mem_wen && core_hold) dmem[mem_addr] <= mem_wdat;

   int passed = 0;
   int total  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [7:0] lb, input logic [8:0] lc,
                           input logic [7:0] db, input logic [8:0] dc);
      start = 1'b1; ld_base = lb; ld_cnt = lc; dp_base = db; dp_cnt = dc;
      tick();
      start = 1'b0;
      // Scramble config inputs: the DUT must use its latched copy.
      ld_base = 8'($urandom); ld_cnt = 9'($urandom); dp_base = 8'($urandom);
      dp_cnt = 9'($urandom);
      chk("start_finished_low", finished, 0);
      if (lc != 0) chk("load_entry_ready", in_ready, 1);
      else chk("zero_load_run", core_hold, 0);
   endtask

   task automatic do_load(input logic [7:0] lb, input int lc, input bit gaps, input bit fixed);
      logic [7:0] a;
      for (int i = 0; i < lc; i++) begin
         if (gaps && $urandom_range(0, 1) == 1) begin
            in_valid = 1'b0; in_data = 8'($urandom);
            #1;
            chk("gap_no_wen", mem_wen, 0);
            chk("gap_ready", in_ready, 1);
            tick();
         end
         in_valid = 1'b1;
         in_data  = fixed ? 8'hA1 + 8'(i) * 8'h11 : 8'($urandom);
         a = lb + 8'(i);
         #1;
         chk("load_wen", mem_wen, 1);
         chk("load_addr", mem_addr, a);
         chk("load_wdat", mem_wdat, in_data);
         exp_mem[a] = in_data;
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic do_run(input int dly);
      for (int c = 0; c < dly; c++) begin
         chk("run_hold_low", core_hold, 0);
         chk("run_no_wen", mem_wen, 0);
         chk("run_addr_zero", mem_addr, 0);
         chk("run_no_out", out_valid, 0);
         chk("run_busy", busy, 1);
         // A start in RUN must be ignored.
         start = (c == 1); ld_cnt = 9'd7;
         tick();
      end
      start = 1'b0;
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      chk("run_exit_hold", core_hold, 1);
   endtask

   // rmode: 0 always ready, 1 pattern 1,0,0 repeating, 2 random. abort_k>=0 stops early.
   task automatic do_dump(input logic [7:0] db, input int dc, input int rmode, input int abort_k);
      int k = 0;
      int cyc = 0;
      bit stall = 0;
      bit rdy;
      logic [7:0] a;
      if (dc == 0) begin
         chk("zero_dump_fin", finished, 1);
         chk("zero_dump_no_out", out_valid, 0);
         return;
      end
      chk("dump_first_empty", out_valid, 0);
      chk("dump_hold", core_hold, 1);
      while (k < dc && cyc < 4 * dc + 20 && !(abort_k >= 0 && k == abort_k)) begin
         rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
         out_ready = rdy;
         a = db + 8'(k);
         #1;
         if (stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, exp_mem[a]);
         end
         if (out_valid && rdy) begin
            chk("dump_data", out_data, exp_mem[a]);
            k++;
         end
         stall = out_valid && !rdy;
         tick();
         cyc++;
      end
      out_ready = 1'b0;
      if (abort_k >= 0) return;
      chk("dump_count", k, dc);
      chk("dump_finished", finished, 1);
      chk("dump_no_extra", out_valid, 0);
      chk("fin_busy_low", busy, 0);
      if (rmode == 0) chk("dump_throughput", cyc, dc + 1);
   endtask

   task automatic round_trip(input logic [7:0] lb, input int lc, input logic [7:0] db,
                             input int dc, input bit gaps, input int rmode, input int dly);
      do_start(lb, 9'(lc), db, 9'(dc));
      do_load(lb, lc, gaps, 1'b0);
      do_run(dly);
      do_dump(db, dc, rmode, -1);
   endtask

   initial begin
      #2000000;
      $error("FAIL watchdog: simulation time limit reached");
      $fatal;
   end

   initial begin
      int n;
      for (int i = 0; i < 256; i++) begin
         dmem[i]    = 8'(i) ^ 8'h5A;
         exp_mem[i] = 8'(i) ^ 8'h5A;
      end
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      core_done = 1'b0; ld_base = '0; ld_cnt = '0; dp_base = '0; dp_cnt = '0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_hold", core_hold, 1);
      chk("rst_busy", busy, 0);
      chk("rst_finished", finished, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_wen", mem_wen, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdat", mem_wdat, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_timeout", timeout, 0);

      // Basic round trip with the fixed byte pattern A1, B2, C3.
      do_start(8'h10, 9'd3, 8'h10, 9'd3);
      do_load(8'h10, 3, 1'b0, 1'b1);
      do_run(5);
      do_dump(8'h10, 3, 0, -1);

      round_trip(8'h20, 4, 8'h20, 4, 1'b0, 1, 3);   // backpressure pattern
      round_trip(8'hFE, 4, 8'hFE, 4, 1'b0, 2, 2);   // address wrap
      round_trip(8'h33, 0, 8'h44, 0, 1'b0, 0, 3);   // zero counts
      round_trip(8'h80, 6, 8'h7E, 9, 1'b1, 2, 4);   // input gaps, overlapping windows

      // Reset in the middle of a dump.
      do_start(8'h40, 9'd5, 8'h40, 9'd5);
      do_load(8'h40, 5, 1'b0, 1'b0);
      do_run(2);
      do_dump(8'h40, 5, 0, 2);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_hold", core_hold, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_finished", finished, 0);
      chk("mid_rst_addr", mem_addr, 0);
      round_trip(8'h00, 8, 8'h00, 8, 1'b1, 2, 3);

      // Whole memory load and dump.
      round_trip(8'h00, 256, 8'h37, 256, 1'b0, 0, 2);

      // Core never signals done.
      do_start(8'h50, 9'd1, 8'h50, 9'd2);
      do_load(8'h50, 1, 1'b0, 1'b0);
`ifdef LOADER_TIMEOUT_EN
      n = 0;
      while (core_hold == 1'b0 && n < 40) begin
         tick();
         n++;
      end
      chk("to_run_cycles", n, TO);
      chk("to_flag", timeout, 1);
      do_dump(8'h50, 2, 0, -1);
      chk("to_sticky", timeout, 1);
      do_start(8'h60, 9'd1, 8'h60, 9'd1);
      chk("to_cleared", timeout, 0);
      do_load(8'h60, 1, 1'b0, 1'b0);
      do_run(2);
      do_dump(8'h60, 1, 0, -1);
      chk("to_stays_low", timeout, 0);
`else
      n = 0;
      for (int c = 0; c < 40; c++) begin
         if (core_hold == 1'b0) n++;
         tick();
      end
      chk("no_to_run_cycles", n, 40);
      chk("no_to_still_run", core_hold, 0);
      chk("no_to_flag", timeout, 0);
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      do_dump(8'h50, 2, 0, -1);
      chk("no_to_flag_end", timeout, 0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
